// File: rtl/sdfa_sram_ctrl.sv
// Weight SRAM access controller: arbitrates between the bank-granular loader (writes)
// and the row-streaming LSTM reader (reads win, bounded by a starvation limit).
module sdfa_sram_ctrl #(
  parameter int NEURON_SIZE_BIT = 8,
  parameter int W_SIZE_BIT      = 14,
  parameter int NUM_BANKS       = 32,
  parameter int STARVE_LIMIT    = 4,
  parameter int READ_LATENCY    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ld_valid,
  output logic                                ld_ready,
  input  logic [NEURON_SIZE_BIT-1:0]          ld_row,
  input  logic [$clog2(NUM_BANKS)-1:0]        ld_bank,
  input  logic [8*W_SIZE_BIT-1:0]             ld_data,
  input  logic                                rd_start,
  input  logic [NEURON_SIZE_BIT-1:0]          rd_base,
  input  logic [NEURON_SIZE_BIT:0]            rd_len,
  output logic                                rd_busy,
  output logic                                rd_done,
  output logic                                row_valid,
  output logic [NEURON_SIZE_BIT-1:0]          row_addr,
  output logic [NUM_BANKS*8*W_SIZE_BIT-1:0]   row_data,
  output logic                                sram_en,
  output logic [NUM_BANKS-1:0]                sram_we,
  output logic [NEURON_SIZE_BIT-1:0]          sram_addr,
  output logic [NEURON_SIZE_BIT-1:0]          sram_addr_write,
  output logic [NUM_BANKS*8*W_SIZE_BIT-1:0]   sram_din,
  input  logic [NUM_BANKS*8*W_SIZE_BIT-1:0]   sram_dout
);

  localparam int ADDR_W     = NEURON_SIZE_BIT;
  localparam int LEN_W      = NEURON_SIZE_BIT + 1;
  localparam int BANK_W     = 8 * W_SIZE_BIT;
  localparam int DATA_W     = NUM_BANKS * BANK_W;
  localparam int BANK_SEL_W = $clog2(NUM_BANKS);
  localparam int STARVE_W   = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [LEN_W-1:0]    remaining_r;
  logic [ADDR_W-1:0]   next_addr_r;
  logic [STARVE_W-1:0] starve_r;
  logic                rd_grant_s;
  logic                ld_ready_s;
  logic                wr_xfer_s;
  logic                start_s;

  logic                sram_en_r;
  logic [NUM_BANKS-1:0] sram_we_r;
  logic [ADDR_W-1:0]   sram_addr_r;
  logic [ADDR_W-1:0]   sram_addr_write_r;
  logic [DATA_W-1:0]   sram_din_r;
  logic                rd_busy_r;
  logic                cmd_v_r;
  logic                cmd_last_r;

  logic                pipe_v_r    [READ_LATENCY];
  logic                pipe_last_r [READ_LATENCY];
  logic [ADDR_W-1:0]   pipe_addr_r [READ_LATENCY];

  // Bank 0 occupies the most significant slice of the row word.
  function automatic logic [DATA_W-1:0] place_bank(input logic [BANK_SEL_W-1:0] bank,
                                                   input logic [BANK_W-1:0]     word);
    return {word, {(DATA_W-BANK_W){1'b0}}} >> (int'(bank) * BANK_W);
  endfunction

  assign start_s   = rd_start && (rd_len != LEN_W'(0));
  assign ld_ready  = ld_ready_s && !rst;
  assign wr_xfer_s = ld_valid && ld_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic; DRAIN ends on the cycle the last row is presented.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_s = STREAM;
        else         state_s = IDLE;
      end
      STREAM: begin
        if (rd_grant_s && (remaining_r == LEN_W'(1))) state_s = DRAIN;
        else                                          state_s = STREAM;
      end
      DRAIN: begin
        if (row_valid && rd_done) state_s = IDLE;
        else                      state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // Grant decode: reads own the port while streaming unless the loader has starved.
  always_comb begin
    rd_grant_s = 1'b0;
    ld_ready_s = 1'b0;
    case (state_r)
      IDLE, DRAIN: begin
        rd_grant_s = 1'b0;
        ld_ready_s = 1'b1;
      end
      STREAM: begin
        if (starve_r == STARVE_W'(STARVE_LIMIT)) begin
          rd_grant_s = 1'b0;
          ld_ready_s = 1'b1;
        end else begin
          rd_grant_s = 1'b1;
          ld_ready_s = 1'b0;
        end
      end
      default: begin
        rd_grant_s = 1'b0;
        ld_ready_s = 1'b0;
      end
    endcase
  end

  // Stream bookkeeping and starvation counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_r <= LEN_W'(0);
      next_addr_r <= ADDR_W'(0);
      starve_r    <= STARVE_W'(0);
    end else begin
      if ((state_r == IDLE) && start_s) begin
        remaining_r <= rd_len;
        next_addr_r <= rd_base;
      end else if (rd_grant_s) begin
        remaining_r <= remaining_r - LEN_W'(1);
        next_addr_r <= next_addr_r + ADDR_W'(1);
      end
      if (wr_xfer_s || !ld_valid) starve_r <= STARVE_W'(0);
      else if (rd_grant_s)        starve_r <= starve_r + STARVE_W'(1);
    end
  end

  // SRAM command register: the op granted this cycle drives the macro next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sram_en_r         <= 1'b0;
      sram_we_r         <= NUM_BANKS'(0);
      sram_addr_r       <= ADDR_W'(0);
      sram_addr_write_r <= ADDR_W'(0);
      sram_din_r        <= DATA_W'(0);
      cmd_v_r           <= 1'b0;
      cmd_last_r        <= 1'b0;
      rd_busy_r         <= 1'b0;
    end else begin
      rd_busy_r <= (state_s != IDLE);
      if (wr_xfer_s) begin
        sram_en_r         <= 1'b1;
        sram_we_r         <= NUM_BANKS'(1) << ld_bank;
        sram_addr_write_r <= ld_row;
        sram_din_r        <= place_bank(ld_bank, ld_data);
        cmd_v_r           <= 1'b0;
        cmd_last_r        <= 1'b0;
      end else if (rd_grant_s) begin
        sram_en_r   <= 1'b1;
        sram_we_r   <= NUM_BANKS'(0);
        sram_addr_r <= next_addr_r;
        cmd_v_r     <= 1'b1;
        cmd_last_r  <= (remaining_r == LEN_W'(1));
      end else begin
        sram_en_r  <= 1'b0;
        sram_we_r  <= NUM_BANKS'(0);
        cmd_v_r    <= 1'b0;
        cmd_last_r <= 1'b0;
      end
    end
  end

  // Read-return pipeline matching the macro's read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_v_r[i]    <= 1'b0;
        pipe_last_r[i] <= 1'b0;
        pipe_addr_r[i] <= ADDR_W'(0);
      end
    end else begin
      pipe_v_r[0]    <= cmd_v_r;
      pipe_last_r[0] <= cmd_last_r;
      pipe_addr_r[0] <= sram_addr_r;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_v_r[i]    <= pipe_v_r[i-1];
        pipe_last_r[i] <= pipe_last_r[i-1];
        pipe_addr_r[i] <= pipe_addr_r[i-1];
      end
    end
  end

  assign sram_en         = sram_en_r;
  assign sram_we         = sram_we_r;
  assign sram_addr       = sram_addr_r;
  assign sram_addr_write = sram_addr_write_r;
  assign sram_din        = sram_din_r;
  assign rd_busy         = rd_busy_r;
  assign row_valid       = pipe_v_r[READ_LATENCY-1];
  assign rd_done         = pipe_last_r[READ_LATENCY-1];
  assign row_addr        = pipe_addr_r[READ_LATENCY-1];
  assign row_data        = sram_dout;

endmodule
